// File: rtl/attention_sv.sv
// attention_sv: value projection and attention output stage.
//   Computes V = I * WV (binary weights), then O = S * V (binary scores),
//   one row per cycle: 4 cycles for V, 4 cycles for O, then O is presented
//   until the downstream handshake. All sums wrap modulo 2^DW.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream S/I/WV valid
//   in_ready   high only in IDLE
//   S          N*N score bits, entry (i,j) at bit i*N+j
//   I          N*D*DW embedding, element (r,c) at [(r*D+c)*DW +: DW]
//   WV         D*D value weight bits, entry (k,c) at bit k*D+c
//   out_valid  O valid (DONE state)
//   out_ready  downstream accepts O
//   O          N*D*DW attention output, same layout as I
//   busy       high while computing V or O
module attention_sv #(
    parameter int N  = 4,
    parameter int D  = 16,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N-1:0]    S,
    input  logic [N*D*DW-1:0] I,
    input  logic [D*D-1:0]    WV,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*D*DW-1:0] O,
    output logic              busy
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = DW + 4;

    typedef enum logic [1:0] {IDLE, CALC_V, CALC_O, DONE} state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [N*N-1:0]      s_q;
    logic [N*D*DW-1:0]   i_q;
    logic [D*D-1:0]      wv_q;
    logic [N*D*DW-1:0]   v_q;
    logic [N*D*DW-1:0]   o_q;
    logic                last_row;

    // One row of V and one row of O, both selected by the shared row counter.
    logic [DW-1:0]       v_row [D];
    logic [DW-1:0]       o_row [D];
    logic [AW-1:0]       v_acc;
    logic [AW-1:0]       o_acc;

    assign last_row = (row_q == RW'(N - 1));
    assign O        = o_q;

    always_comb begin
        v_acc = '0;
        for (int unsigned c = 0; c < D; c++) begin
            v_acc = '0;
            for (int unsigned k = 0; k < D; k++) begin
                if (wv_q[k*D + c]) begin
                    v_acc = v_acc + AW'(i_q[(int'(row_q)*D + k)*DW +: DW]);
                end
            end
            v_row[c] = v_acc[DW-1:0];
        end
    end

    always_comb begin
        o_acc = '0;
        for (int unsigned c = 0; c < D; c++) begin
            o_acc = '0;
            for (int unsigned j = 0; j < N; j++) begin
                if (s_q[int'(row_q)*N + j]) begin
                    o_acc = o_acc + AW'(v_q[(j*D + c)*DW +: DW]);
                end
            end
            o_row[c] = o_acc[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC_V;
                    row_d   = '0;
                end
            end
            CALC_V: begin
                busy = 1'b1;
                if (last_row) begin
                    state_d = CALC_O;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            CALC_O: begin
                busy = 1'b1;
                if (last_row) begin
                    state_d = DONE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q  <= '0;
            i_q  <= '0;
            wv_q <= '0;
            v_q  <= '0;
            o_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q  <= S;
                        i_q  <= I;
                        wv_q <= WV;
                    end
                end
                CALC_V: begin
                    for (int unsigned c = 0; c < D; c++) begin
                        v_q[(int'(row_q)*D + c)*DW +: DW] <= v_row[c];
                    end
                end
                CALC_O: begin
                    for (int unsigned c = 0; c < D; c++) begin
                        o_q[(int'(row_q)*D + c)*DW +: DW] <= o_row[c];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
